// File: rtl/board_pkg.sv
// Shared board definitions: move FSM states, tile index type and sprite placement
// offsets used by the move scheduler and the player renderers.
package board_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MOVE,
    ARRIVE,
    DONE
  } state_t;

  typedef logic [4:0] tile_t;

  localparam logic [9:0] P1_OFF_X     = 10'd0;
  localparam logic [9:0] P2_OFF_X     = 10'd16;
  localparam logic [9:0] SPRITE_OFF_Y = 10'd8;

  localparam int unsigned SPRITE_PX = 16;

endpackage

// File: rtl/player_move_scheduler_if.sv
// Move-request handshake between the game controller (master) and the
// move scheduler (slave), including the completion pulse.
interface player_move_scheduler_if;

  logic       move_valid;
  logic       move_ready;
  logic       move_player;
  logic [2:0] move_steps;
  logic       move_done;

  modport master (
    output move_valid,
    output move_player,
    output move_steps,
    input  move_ready,
    input  move_done
  );

  modport slave (
    input  move_valid,
    input  move_player,
    input  move_steps,
    output move_ready,
    output move_done
  );

endinterface

// File: rtl/board_tile_coord.sv
// Combinational tile index + player id to sprite top-left screen position
// along the serpentine board path.
module board_tile_coord
  import board_pkg::*;
#(
  parameter int unsigned COLS     = 8,
  parameter int unsigned TILE_PX  = 32,
  parameter int unsigned BOARD_X0 = 64,
  parameter int unsigned BOARD_Y0 = 96
) (
  input  tile_t       tile,
  input  logic        player,
  output logic [9:0]  x,
  output logic [9:0]  y
);

  localparam logic [9:0] COLS_W = 10'(COLS);
  localparam logic [9:0] TILE_W = 10'(TILE_PX);
  localparam logic [9:0] X0_W   = 10'(BOARD_X0);
  localparam logic [9:0] Y0_W   = 10'(BOARD_Y0);

  logic [9:0] idx;
  logic [9:0] row;
  logic [9:0] c;
  logic [9:0] col;

  always_comb begin
    idx = {5'd0, tile};
    row = idx / COLS_W;
    c   = idx % COLS_W;
    // odd rows run right-to-left
    col = row[0] ? (COLS_W - 10'd1 - c) : c;
    x   = X0_W + col * TILE_W + (player ? P2_OFF_X : P1_OFF_X);
    y   = Y0_W + row * TILE_W + SPRITE_OFF_Y;
  end

endmodule

// File: rtl/player_move_scheduler.sv
// Accepts one move request at a time and walks the chosen sprite tile by tile,
// stepping pixels only on frame ticks; latches the first player to reach the goal.
module player_move_scheduler
  import board_pkg::*;
#(
  parameter int unsigned NUM_TILES = 24,
  parameter int unsigned COLS      = 8,
  parameter int unsigned TILE_PX   = 32,
  parameter int unsigned PIX_STEP  = 2,
  parameter int unsigned BOARD_X0  = 64,
  parameter int unsigned BOARD_Y0  = 96
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    game_reset,
  player_move_scheduler_if.slave  bus,
  output logic [9:0]              p1_x,
  output logic [9:0]              p1_y,
  output logic [9:0]              p2_x,
  output logic [9:0]              p2_y,
  output tile_t                   p1_tile,
  output tile_t                   p2_tile,
  output logic                    busy,
  output logic                    winner_valid,
  output logic                    winner_id
);

  localparam tile_t      GOAL  = tile_t'(NUM_TILES - 1);
  localparam logic [9:0] PIX_W = 10'(PIX_STEP);

  state_t     state, state_next;
  logic       player;
  logic [2:0] steps;
  logic [9:0] tgt_x, tgt_y;
  logic [9:0] tgt_x_c, tgt_y_c;
  logic [9:0] home_x, home_y, home_p2_x;
  tile_t      cur_tile, next_tile;
  logic [9:0] cur_x, cur_y;
  logic [9:0] step_x, step_y;
  logic       arrived;
  logic       accept;

  board_tile_coord #(
    .COLS(COLS), .TILE_PX(TILE_PX), .BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0)
  ) u_target (
    .tile(next_tile), .player(player), .x(tgt_x_c), .y(tgt_y_c)
  );

  board_tile_coord #(
    .COLS(COLS), .TILE_PX(TILE_PX), .BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0)
  ) u_home (
    .tile('0), .player(1'b0), .x(home_x), .y(home_y)
  );

  assign home_p2_x = home_x + (P2_OFF_X - P1_OFF_X);

  always_comb begin
    cur_tile  = player ? p2_tile : p1_tile;
    cur_x     = player ? p2_x : p1_x;
    cur_y     = player ? p2_y : p1_y;
    next_tile = cur_tile + tile_t'(1);
    accept    = (state == IDLE) && bus.move_valid && bus.move_ready && !game_reset;
    step_x    = cur_x;
    step_y    = cur_y;
    // horizontal travel first; vertical only once the column is reached
    if (cur_x != tgt_x)
      step_x = (cur_x < tgt_x) ? cur_x + PIX_W : cur_x - PIX_W;
    else if (cur_y != tgt_y)
      step_y = (cur_y < tgt_y) ? cur_y + PIX_W : cur_y - PIX_W;
    arrived = (step_x == tgt_x) && (step_y == tgt_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (game_reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = LOAD;
        LOAD:    state_next = (steps == 3'd0 || cur_tile == GOAL) ? DONE : MOVE;
        MOVE:    if (frame_tick && arrived) state_next = ARRIVE;
        ARRIVE:  state_next = (next_tile == GOAL) ? DONE
                            : (steps > 3'd1)      ? LOAD : DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.move_ready = (state == IDLE) && !winner_valid;
    bus.move_done  = (state == DONE);
    busy           = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_tile      <= '0;
      p2_tile      <= '0;
      p1_x         <= home_x;
      p1_y         <= home_y;
      p2_x         <= home_p2_x;
      p2_y         <= home_y;
      player       <= 1'b0;
      steps        <= '0;
      tgt_x        <= '0;
      tgt_y        <= '0;
      winner_valid <= 1'b0;
      winner_id    <= 1'b0;
    end else if (game_reset) begin
      p1_tile      <= '0;
      p2_tile      <= '0;
      p1_x         <= home_x;
      p1_y         <= home_y;
      p2_x         <= home_p2_x;
      p2_y         <= home_y;
      winner_valid <= 1'b0;
      winner_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            player <= bus.move_player;
            steps  <= bus.move_steps;
          end
        end
        LOAD: begin
          tgt_x <= tgt_x_c;
          tgt_y <= tgt_y_c;
        end
        MOVE: begin
          if (frame_tick) begin
            if (player) begin
              p2_x <= step_x;
              p2_y <= step_y;
            end else begin
              p1_x <= step_x;
              p1_y <= step_y;
            end
          end
        end
        ARRIVE: begin
          if (player) p2_tile <= next_tile;
          else        p1_tile <= next_tile;
          steps <= steps - 3'd1;
          if (next_tile == GOAL && !winner_valid) begin
            winner_valid <= 1'b1;
            winner_id    <= player;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_scheduler.sv
// Directed and randomized moves checked against a tile-level board model that
// predicts every intermediate sprite position from the serpentine layout.
module tb_player_move_scheduler;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       game_reset;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [4:0] p1_tile, p2_tile;
  logic       busy, winner_valid, winner_id;

  player_move_scheduler_if bus();

  player_move_scheduler #(
    .NUM_TILES(24), .COLS(8), .TILE_PX(32), .PIX_STEP(2), .BOARD_X0(64), .BOARD_Y0(96)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_reset(game_reset),
    .bus(bus),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_tile(p1_tile), .p2_tile(p2_tile),
    .busy(busy), .winner_valid(winner_valid), .winner_id(winner_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mtile[2];
  bit mwin;
  bit mwin_id;

  function automatic int exp_x(input int t, input int p);
    int row, c, col;
    row = t / 8;
    c   = t % 8;
    col = (row % 2 == 1) ? 7 - c : c;
    return 64 + col * 32 + (p == 1 ? 16 : 0);
  endfunction

  function automatic int exp_y(input int t);
    return 96 + (t / 8) * 32 + 8;
  endfunction

  function automatic int get_x(input int p);
    return (p == 1) ? int'(p2_x) : int'(p1_x);
  endfunction

  function automatic int get_y(input int p);
    return (p == 1) ? int'(p2_y) : int'(p1_y);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_rest(input string tag);
    check({tag, "_p1_tile"}, 32'(p1_tile), mtile[0]);
    check({tag, "_p2_tile"}, 32'(p2_tile), mtile[1]);
    check({tag, "_p1_x"}, 32'(p1_x), exp_x(mtile[0], 0));
    check({tag, "_p1_y"}, 32'(p1_y), exp_y(mtile[0]));
    check({tag, "_p2_x"}, 32'(p2_x), exp_x(mtile[1], 1));
    check({tag, "_p2_y"}, 32'(p2_y), exp_y(mtile[1]));
    check({tag, "_win_v"}, 32'(winner_valid), 32'(mwin));
    if (mwin) check({tag, "_win_id"}, 32'(winner_id), 32'(mwin_id));
  endtask

  task automatic do_move(input int p, input int s);
    int st, eff, total, seg, j, fx, fy, tx, ty, q, gap;
    st = mtile[p];
    q  = 1 - p;
    if (mwin) begin
      check("ready_after_win", 32'(bus.move_ready), 0);
      bus.move_valid = 1'b1; bus.move_player = p[0]; bus.move_steps = s[2:0];
      @(negedge clk);
      bus.move_valid = 1'b0;
      check("busy_after_win", 32'(busy), 0);
      repeat (2) @(negedge clk);
      check("done_after_win", 32'(bus.move_done), 0);
      check_rest("ignored");
    end else begin
      check("ready_idle", 32'(bus.move_ready), 1);
      bus.move_valid = 1'b1; bus.move_player = p[0]; bus.move_steps = s[2:0];
      @(negedge clk);
      bus.move_valid = 1'b0;
      check("busy_load", 32'(busy), 1);
      eff   = (s < 23 - st) ? s : 23 - st;
      total = eff * 16;
      if (eff == 0) begin
        // ticks held through LOAD and DONE must not move anything
        frame_tick = 1'b1;
        @(negedge clk);
        check("zero_done", 32'(bus.move_done), 1);
        @(negedge clk);
        frame_tick = 1'b0;
        check("zero_done_pulse", 32'(bus.move_done), 0);
        check("zero_busy", 32'(busy), 0);
        check_rest("zero");
      end else begin
        for (int k = 1; k <= total; k++) begin
          gap = int'($urandom_range(2, 4));
          repeat (gap) @(negedge clk);
          frame_tick = 1'b1;
          @(negedge clk);
          frame_tick = 1'b0;
          seg = (k - 1) / 16;
          j   = (k - 1) % 16 + 1;
          fx  = exp_x(st + seg, p);     fy = exp_y(st + seg);
          tx  = exp_x(st + seg + 1, p); ty = exp_y(st + seg + 1);
          check("act_x", 32'(get_x(p)), fx + (tx - fx) * j / 16);
          check("act_y", 32'(get_y(p)), fy + (ty - fy) * j / 16);
          check("idle_x", 32'(get_x(q)), exp_x(mtile[q], q));
          check("idle_y", 32'(get_y(q)), exp_y(mtile[q]));
          check("done_early", 32'(bus.move_done), 0);
        end
        @(negedge clk);
        check("done_pulse", 32'(bus.move_done), 1);
        @(negedge clk);
        check("done_clear", 32'(bus.move_done), 0);
        check("busy_end", 32'(busy), 0);
        mtile[p] = st + eff;
        if (mtile[p] == 23 && !mwin) begin
          mwin    = 1'b1;
          mwin_id = p[0];
        end
        check_rest("move");
      end
    end
  endtask

  task automatic do_game_reset(input bit with_req);
    game_reset = 1'b1;
    bus.move_valid = with_req; bus.move_player = 1'b0; bus.move_steps = 3'd5;
    @(negedge clk);
    game_reset = 1'b0;
    bus.move_valid = 1'b0;
    mtile[0] = 0; mtile[1] = 0; mwin = 1'b0; mwin_id = 1'b0;
    check("grst_busy", 32'(busy), 0);
    check("grst_done", 32'(bus.move_done), 0);
    check("grst_ready", 32'(bus.move_ready), 1);
    check_rest("grst");
    @(negedge clk);
    check("grst_dropped", 32'(busy), 0);
    check("grst_done2", 32'(bus.move_done), 0);
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; game_reset = 1'b0;
    bus.move_valid = 1'b0; bus.move_player = 1'b0; bus.move_steps = 3'd0;
    mtile[0] = 0; mtile[1] = 0; mwin = 1'b0; mwin_id = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p1_x", 32'(p1_x), 64);
    check("rst_p1_y", 32'(p1_y), 104);
    check("rst_p2_x", 32'(p2_x), 80);
    check("rst_p2_y", 32'(p2_y), 104);
    check("rst_busy", 32'(busy), 0);
    check("rst_win", 32'(winner_valid), 0);
    check("rst_win_id", 32'(winner_id), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.move_ready), 1);
    check_rest("rst");

    do_move(0, 1);
    check("p1_one_x", 32'(p1_x), 96);
    check("p1_one_tile", 32'(p1_tile), 1);

    do_move(1, 6);
    do_move(1, 3);
    check("wrap_p2_x", 32'(p2_x), 272);
    check("wrap_p2_y", 32'(p2_y), 136);
    check("wrap_p2_tile", 32'(p2_tile), 9);

    do_move(0, 0);

    repeat (6) do_move(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));

    do_game_reset(1'b1);

    do_move(0, 7);
    do_move(0, 7);
    do_move(0, 7);
    do_move(0, 6);
    check("goal_tile", 32'(p1_tile), 23);
    check("goal_win", 32'(winner_valid), 1);
    check("goal_win_id", 32'(winner_id), 0);
    do_move(1, 2);

    do_game_reset(1'b0);

    // abort a move part-way with a simultaneous (dropped) request
    bus.move_valid = 1'b1; bus.move_player = 1'b1; bus.move_steps = 3'd3;
    @(negedge clk);
    bus.move_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (2) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    check("mid_x", 32'(p2_x), 90);
    do_game_reset(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
